// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the serial_adder codebase slice.
// Holds the control-state encoding and the digit-counter width calculation.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for N digit steps: enough bits to hold N-1, never below one bit.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/fa_slice.sv
// fa_slice: purely combinational DIGIT-bit ripple of full-adder cells.
// c_msb exposes the carry entering the top bit so the parent can derive
// two's-complement overflow when it wants to.
module fa_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] carry_s;

    // Ripple the carry through DIGIT full-adder cells, LSB first.
    always_comb begin
        s          = '0;
        carry_s    = '0;
        carry_s[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
        end
    end

    assign co    = carry_s[DIGIT];
    assign c_msb = carry_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder computing {cout,sum} = a + b + cin by
// pushing DIGIT bits per cycle through one fa_slice over WIDTH/DIGIT cycles.
// Handshake: start is accepted in IDLE or DONE; busy covers the RUN cycles;
// done pulses for one cycle with sum/cout valid and held afterwards.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    // Reject geometries where the slice cannot tile the operand exactly.
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "serial_adder: DIGIT must divide WIDTH exactly (WIDTH=%0d DIGIT=%0d)", WIDTH, DIGIT);
    end

    state_t           state_r;
    state_t           state_next_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             carry_r;
    logic [DIGIT-1:0] slice_sum_s;
    logic             slice_co_s;
    logic [WIDTH-1:0] res_next_s;
    logic             accept_s;
    logic             last_s;
`ifdef SERIAL_ADDER_OVF_EN
    logic             slice_c_msb_s;
`else
    logic             unused_c_msb_s;
`endif

    fa_slice #(
        .DIGIT (DIGIT)
    ) u_fa_slice (
        .a     (a_sh_r[DIGIT-1:0]),
        .b     (b_sh_r[DIGIT-1:0]),
        .ci    (carry_r),
`ifdef SERIAL_ADDER_OVF_EN
        .c_msb (slice_c_msb_s),
`else
        .c_msb (unused_c_msb_s),
`endif
        .s     (slice_sum_s),
        .co    (slice_co_s)
    );

    assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));
    assign last_s     = (cnt_r == LAST_CNT);
    // New digit enters at the top; after N steps the LSB digit sits at the bottom.
    assign res_next_s = WIDTH'({slice_sum_s, res_sh_r} >> DIGIT);

    // Next-state decode: RUN for N cycles, one DONE cycle, optional immediate restart.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy    <= (state_next_s == RUN);
            done    <= (state_next_s == DONE);
        end
    end

    // Datapath: latch operands on accept, step one digit per RUN cycle, publish on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= '0;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            carry_r  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf      <= 1'b0;
`endif
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            carry_r  <= cin;
            res_sh_r <= '0;
            cnt_r    <= '0;
        end else if (state_r == RUN) begin
            a_sh_r   <= a_sh_r >> DIGIT;
            b_sh_r   <= b_sh_r >> DIGIT;
            res_sh_r <= res_next_s;
            carry_r  <= slice_co_s;
            if (last_s) begin
                // Hold the counter at its final value so it never wraps.
                sum  <= res_next_s;
                cout <= slice_co_s;
`ifdef SERIAL_ADDER_OVF_EN
                ovf  <= slice_c_msb_s ^ slice_co_s;
`endif
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder.
// Three instances (8/1, 8/4, 4/2) share operand inputs; a selector routes
// start to one instance and picks which outputs are observed.
// Optional feature macro: SERIAL_ADDER_OVF_EN enables ovf checks.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start_in;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cin_in;
    int         sel;

    logic       busy0, done0, cout0;
    logic       busy1, done1, cout1;
    logic       busy2, done2, cout2;
    logic [7:0] sum0, sum1;
    logic [3:0] sum2;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf0, ovf1, ovf2, ovf_sel;
`endif

    logic       busy_sel, done_sel, cout_sel;
    logic [7:0] sum_sel;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst(rst), .start(start_in && (sel == 0)),
        .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy0), .done(done0), .sum(sum0),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf0),
`endif
        .cout(cout0)
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst(rst), .start(start_in && (sel == 1)),
        .a(a_in), .b(b_in), .cin(cin_in),
        .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf1),
`endif
        .cout(cout1)
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst(rst), .start(start_in && (sel == 2)),
        .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin_in),
        .busy(busy2), .done(done2), .sum(sum2),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf2),
`endif
        .cout(cout2)
    );

    assign busy_sel = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    assign done_sel = (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
    assign cout_sel = (sel == 0) ? cout0 : (sel == 1) ? cout1 : cout2;
    assign sum_sel  = (sel == 0) ? sum0  : (sel == 1) ? sum1  : {4'h0, sum2};
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_sel  = (sel == 0) ? ovf0  : (sel == 1) ? ovf1  : ovf2;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge. Presents one start, then waits for done.
    // lat counts edges from the accepting edge through the enter-DONE edge inclusive.
    task automatic run_op(input int s, input logic [7:0] aa, input logic [7:0] bb,
                          input logic cc, input bit glitch,
                          output int lat, output int busy_cnt);
        sel      = s;
        a_in     = aa;
        b_in     = bb;
        cin_in   = cc;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!done_sel && lat < 64) begin
            if (busy_sel) busy_cnt++;
            if (glitch && lat == 2) begin
                start_in = 1'b1;
                a_in     = 8'h00;
            end else begin
                start_in = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start_in = 1'b0;
        check("busy_done_excl", 32'(busy_sel & done_sel), 32'd0);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    int lat, bcnt, dcount;
    logic [4:0] exp5;
    logic [3:0] ai, bi;

    initial begin
        rst      = 1'b1;
        start_in = 1'b0;
        a_in     = 8'h00;
        b_in     = 8'h00;
        cin_in   = 1'b0;
        sel      = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_sum",  32'(sum0),  32'd0);
        check("rst_cout", 32'(cout0), 32'd0);
        check("rst_sum_w4", 32'(sum2), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf0), 32'd0);
`endif
        rst = 1'b0;
        idle_cycle();

        // 0x0F + 0x01 on 8/1: latency 9 edges, busy for 8 cycles
        run_op(0, 8'h0F, 8'h01, 1'b0, 1'b0, lat, bcnt);
        check("t1_sum",  32'(sum_sel),  32'h10);
        check("t1_cout", 32'(cout_sel), 32'd0);
        check("t1_lat",  32'(lat),      32'd9);
        check("t1_busy", 32'(bcnt),     32'd8);
        idle_cycle();
        check("t1_done_pulse", 32'(done_sel), 32'd0);
        check("t1_sum_hold",   32'(sum_sel),  32'h10);

        run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, lat, bcnt);
        check("t2_sum",  32'(sum_sel),  32'h00);
        check("t2_cout", 32'(cout_sel), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
        check("t2_ovf",  32'(ovf_sel),  32'd0);
`endif
        idle_cycle();
        run_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, lat, bcnt);
        check("t2b_sum",  32'(sum_sel),  32'h80);
        check("t2b_cout", 32'(cout_sel), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("t2b_ovf",  32'(ovf_sel),  32'd1);
`endif
        idle_cycle();

        // 0xA5 + 0x5B + 1 on 8/4 with a start pulse (a=0) during RUN
        run_op(1, 8'hA5, 8'h5B, 1'b1, 1'b1, lat, bcnt);
        check("t3_sum",  32'(sum_sel),  32'h01);
        check("t3_cout", 32'(cout_sel), 32'd1);
        check("t3_lat",  32'(lat),      32'd3);
        check("t3_busy", 32'(bcnt),     32'd2);
`ifdef SERIAL_ADDER_OVF_EN
        check("t3_ovf",  32'(ovf_sel),  32'd0);
`endif

        // Back-to-back: start asserted in the DONE cycle
        run_op(1, 8'h02, 8'h03, 1'b0, 1'b0, lat, bcnt);
        check("t4_sum",  32'(sum_sel),  32'h05);
        check("t4_cout", 32'(cout_sel), 32'd0);
        check("t4_lat",  32'(lat),      32'd3);
        check("t4_busy", 32'(bcnt),     32'd2);
        idle_cycle();
        idle_cycle();
        check("t4_sum_hold", 32'(sum_sel), 32'h05);

        // Reset three cycles after accept on 8/1 (sum currently 0x80)
        sel      = 0;
        a_in     = 8'h0F;
        b_in     = 8'h01;
        cin_in   = 1'b0;
        start_in = 1'b1;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        check("t5_busy_before", 32'(busy0), 32'd1);
        repeat (2) idle_cycle();
        rst = 1'b1;
        idle_cycle();
        check("t5_busy", 32'(busy0), 32'd0);
        check("t5_done", 32'(done0), 32'd0);
        check("t5_sum",  32'(sum0),  32'd0);
        check("t5_cout", 32'(cout0), 32'd0);
        rst    = 1'b0;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            idle_cycle();
            if (done0) dcount++;
        end
        check("t5_no_done", 32'(dcount), 32'd0);
        run_op(0, 8'h03, 8'h04, 1'b0, 1'b0, lat, bcnt);
        check("t5_after_sum", 32'(sum_sel), 32'h07);
        check("t5_after_lat", 32'(lat),     32'd9);
        idle_cycle();

        // Exhaustive sweep on 4/2 against a+b+cin
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 2; k++) begin
                    ai   = 4'(i);
                    bi   = 4'(j);
                    exp5 = {1'b0, ai} + {1'b0, bi} + 5'(k);
                    run_op(2, {4'h0, ai}, {4'h0, bi}, k[0], 1'b0, lat, bcnt);
                    check("sweep", 32'({cout_sel, sum_sel[3:0]}), 32'(exp5));
`ifdef SERIAL_ADDER_OVF_EN
                    check("sweep_ovf", 32'(ovf_sel),
                          32'((ai[3] == bi[3]) && (exp5[3] != ai[3])));
`endif
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
